// File: rtl/ctrl_sd_itf.sv
// Scan controller for a 6-digit serial 7-segment display: sequences load/shift/latch/hold
// and drives the shcp/stcp pins. Define CTRL_SD_ITF_BLINK_EN to enable blink phase on tw.
module ctrl_sd_itf #(
  parameter int CLK_DIV    = 2,
  parameter int SHIFT_BITS = 14,
  parameter int HOLD_CYC   = 5000,
  parameter int BLINK_CYC  = 2500000
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [5:0] dp_mask,
  input  logic [5:0] blink_mask,
  output logic [5:0] sel,
  output logic [5:0] sel_sd,
  output logic       dp,
  output logic       tw,
  output logic       upgrade,
  output logic       move,
  output logic       keep,
  output logic       shcp,
  output logic       stcp
);

  localparam int CNT_MAX = (HOLD_CYC > CLK_DIV) ? HOLD_CYC : CLK_DIV;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(SHIFT_BITS);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, LATCH, HOLD} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic               shcp_d, stcp_d;
  logic               half_end, last_bit;
  logic               advance;  // HOLD last cycle: rotate to the next digit
  logic               sample;   // edge into LOAD: capture per-digit attributes
  logic [5:0]         load_sel;

  assign half_end = (cnt_q == CNT_W'(CLK_DIV - 1));
  assign last_bit = (bit_q == BIT_W'(SHIFT_BITS - 1));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shcp_d  = shcp;
    stcp_d  = stcp;
    advance = 1'b0;
    sample  = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = LOAD;
          sample  = 1'b1;
        end
      end
      LOAD: begin
        state_d = SHIFT;
        cnt_d   = '0;
        bit_d   = '0;
        shcp_d  = 1'b0;
      end
      SHIFT: begin
        if (half_end) begin
          cnt_d  = '0;
          shcp_d = ~shcp;
          // High half ends on the same edge the datapath rotates, so ds settles while shcp is low.
          if (shcp) begin
            if (last_bit) begin
              state_d = LATCH;
              stcp_d  = 1'b1;
            end else begin
              bit_d = bit_q + BIT_W'(1);
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LATCH: begin
        if (half_end) begin
          state_d = HOLD;
          stcp_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
          advance = 1'b1;
          cnt_d   = '0;
          if (en) begin
            state_d = LOAD;
            sample  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shcp    <= 1'b0;
      stcp    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shcp    <= shcp_d;
      stcp    <= stcp_d;
    end
  end

  assign upgrade  = (state_q == LOAD);
  assign move     = (state_q == SHIFT) && shcp && half_end && !last_bit;
  assign keep     = ((state_q == SHIFT) || (state_q == LATCH) || (state_q == HOLD)) && !move;
  assign load_sel = advance ? {sel[0], sel[5:1]} : sel;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      sel    <= 6'b100000;
      sel_sd <= 6'b000000;
      dp     <= 1'b0;
    end else begin
      if (advance) begin
        sel <= load_sel;
      end
      if (advance || sample) begin
        sel_sd <= load_sel;
      end
      if (sample) begin
        dp <= |(dp_mask & load_sel);
      end
    end
  end

`ifdef CTRL_SD_ITF_BLINK_EN
  localparam int BLK_W = $clog2(BLINK_CYC + 1);

  logic [BLK_W-1:0] blink_cnt;
  logic             phase;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
      tw        <= 1'b0;
    end else begin
      if (blink_cnt == BLK_W'(BLINK_CYC - 1)) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + BLK_W'(1);
      end
      if (sample) begin
        tw <= |(blink_mask & load_sel) & phase;
      end
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{blink_mask, 32'(BLINK_CYC)};
  assign tw = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_sd_itf.sv
// Scoreboard bench for ctrl_sd_itf: stimulus queues expected frame attributes, a negedge
// monitor pops them at each upgrade and checks pin/strobe timing against a frame-position model.
module tb_ctrl_sd_itf;

  localparam int CD        = 2;
  localparam int SB        = 14;
  localparam int HC        = 4;
  localparam int BC        = 8;
  localparam int SHIFT_CYC = 2 * SB * CD;
  localparam int FRAME     = 1 + SHIFT_CYC + CD + HC;
  localparam int PERIOD    = 10;

  logic       sysclk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [5:0] dp_mask, blink_mask;
  logic [5:0] sel, sel_sd;
  logic       dp, tw, upgrade, move, keep, shcp, stcp;

  ctrl_sd_itf #(.CLK_DIV(CD), .SHIFT_BITS(SB), .HOLD_CYC(HC), .BLINK_CYC(BC)) dut (
    .sysclk(sysclk), .rst_n(rst_n), .en(en), .dp_mask(dp_mask), .blink_mask(blink_mask),
    .sel(sel), .sel_sd(sel_sd), .dp(dp), .tw(tw), .upgrade(upgrade), .move(move),
    .keep(keep), .shcp(shcp), .stcp(stcp)
  );

  always #(PERIOD / 2) sysclk = ~sysclk;

  typedef struct {
    logic [5:0] sel;
    logic       dp;
    logic       tw;
    int         gap;
    time        due;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   digit    = 0;
  int   n_edges  = 0;
  int   pos      = FRAME;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected {move, keep, shcp, stcp} at cycle p of a frame (p=0 is the LOAD cycle).
  function automatic logic [3:0] pin_model(input int p);
    int   w, b;
    logic mv;
    if (p == 0 || p >= FRAME) return 4'b0000;
    if (p <= SHIFT_CYC) begin
      w  = (p - 1) % (2 * CD);
      b  = (p - 1) / (2 * CD);
      mv = (w == 2 * CD - 1) && (b < SB - 1);
      return {mv, !mv, (w >= CD), 1'b0};
    end
    if (p <= SHIFT_CYC + CD) return 4'b0101;
    return 4'b0100;
  endfunction

  always @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) n_edges <= 0;
    else        n_edges <= n_edges + 1;
  end

  // Monitor: decoupled from stimulus, driven only by DUT outputs and the expectation queue.
  always @(negedge sysclk) begin
    logic due;
    exp_t e;
    if (!rst_n) begin
      check("rst_sel", sel, 6'b100000);
      check("rst_sel_sd", sel_sd, 6'b000000);
      check("rst_dp_tw", {dp, tw}, 2'b00);
      check("rst_strobes", {upgrade, move, keep, shcp, stcp}, 5'b0);
      pos = FRAME;
    end else begin
      due = (exp_q.size() != 0) && (exp_q[0].due <= $time);
      if (upgrade || due) begin
        check("upgrade_timing", upgrade, due);
        if (due) begin
          e = exp_q.pop_front();
          if (upgrade) begin
            check("sel", sel, e.sel);
            check("sel_sd", sel_sd, e.sel);
            check("dp", dp, e.dp);
            check("tw", tw, e.tw);
            if (e.gap != 0) check("frame_gap", pos + 1, e.gap);
          end
        end
      end
      if (upgrade) pos = 0;
      else if (pos < FRAME) pos++;
      check("pins", {move, keep, shcp, stcp}, pin_model(pos));
      check("exclusive", ($countones({upgrade, move, keep}) <= 1), 1);
    end
  end

  task automatic push_frame(input int gap);
    exp_t e;
    e.sel = 6'b100000 >> digit;
    e.dp  = dp_mask[5 - digit];
`ifdef CTRL_SD_ITF_BLINK_EN
    e.tw  = blink_mask[5 - digit] & (((n_edges / BC) % 2) == 1);
`else
    e.tw  = 1'b0;
`endif
    e.gap = gap;
    e.due = $time + PERIOD;
    exp_q.push_back(e);
    digit = (digit + 1) % 6;
  endtask

  // Runs n back-to-back frames, drops en 'drop' cycles into the last one, and waits for IDLE.
  task automatic run_episode(input int n, input int drop, input bit rnd,
                             input logic [5:0] dpm, input logic [5:0] bkm);
    for (int f = 0; f < n; f++) begin
      dp_mask    = rnd ? 6'($urandom) : dpm;
      blink_mask = rnd ? 6'($urandom) : bkm;
      en         = 1'b1;
      push_frame((f == 0) ? 0 : FRAME);
      @(negedge sysclk);
      if (rnd) begin
        dp_mask    = 6'($urandom);
        blink_mask = 6'($urandom);
      end
      if (f < n - 1) repeat (FRAME - 1) @(negedge sysclk);
    end
    repeat (drop - 1) @(negedge sysclk);
    en = 1'b0;
    repeat (FRAME - drop) @(negedge sysclk);
  endtask

  initial begin
    rst_n      = 1'b0;
    en         = 1'b0;
    dp_mask    = 6'b0;
    blink_mask = 6'b0;
    repeat (3) @(negedge sysclk);
    rst_n = 1'b1;

    repeat (100) @(negedge sysclk);
    check("idle_sel", sel, 6'b100000);
    check("idle_sel_sd", sel_sd, 6'b000000);
    check("idle_dp_tw", {dp, tw}, 2'b00);

    // Seven frames with a fixed decimal point on digit 3, blink on digit 6, en dropped at bit 5.
    run_episode(7, 22, 1'b0, 6'b000100, 6'b100000);
    repeat (10) @(negedge sysclk);
    check("after_drop_pins", {upgrade, move, keep, shcp, stcp}, 5'b0);
    check("after_drop_sel", sel, 6'b010000);

    // Resume from the advanced digit, then reset during shift bit 7.
    run_episode(1, 62, 1'b0, 6'b000010, 6'b010000);
    en         = 1'b1;
    dp_mask    = 6'b111111;
    blink_mask = 6'b000000;
    push_frame(0);
    repeat (30) @(negedge sysclk);
    #2;
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    check("async_rst_sel", sel, 6'b100000);
    check("async_rst_pins", {upgrade, move, keep, shcp, stcp}, 5'b0);
    check("async_rst_sel_sd", sel_sd, 6'b000000);
    repeat (2) @(negedge sysclk);
    rst_n = 1'b1;
    digit = 0;
    repeat (5) @(negedge sysclk);

    for (int i = 0; i < 10; i++) begin
      run_episode($urandom_range(1, 7), $urandom_range(1, 62), 1'b1, 6'b0, 6'b0);
      repeat ($urandom_range(0, 12)) @(negedge sysclk);
    end

    repeat (20) @(negedge sysclk);
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
